// File: rtl/demo_unit.sv
// Self-running demo datapath: free-running counter -> op-sequenced ALU -> registered result, zero flag, XOR checksum.
// Define DEMO_SHIFT_EN to add the SLL/SRL ops to the sequence.
module demo_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   output logic [WIDTH-1:0] cnt,
   output logic [2:0]       op,
   output logic [WIDTH-1:0] alu_out,
   output logic             zero,
   output logic [WIDTH-1:0] checksum
);

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_SLL = 3'd4,
      OP_SRL = 3'd5
   } op_e;

   op_e              state;
   op_e              next_state;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] f;

   // Operand b is cnt with its two halves swapped.
   assign a  = cnt;
   assign b  = {cnt[WIDTH/2-1:0], cnt[WIDTH-1:WIDTH/2]};
   assign op = state;

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      if (reset) begin
         state    <= OP_ADD;
         cnt      <= '0;
         alu_out  <= '0;
         zero     <= 1'b1;
         checksum <= '0;
      end else begin
         state    <= next_state;
         cnt      <= cnt + 1'b1;
         alu_out  <= f;
         zero     <= (f == '0);
         checksum <= checksum ^ f;
      end
   end

   always_comb begin
      // NOTE: defaults first so no path through the case leaves f or next_state unassigned (no latch).
      f          = '0;
      next_state = OP_ADD;
      case (state)
         OP_ADD: begin
            f          = a + b;
            next_state = OP_SUB;
         end
         OP_SUB: begin
            f          = a - b;
            next_state = OP_AND;
         end
         OP_AND: begin
            f          = a & b;
            next_state = OP_OR;
         end
`ifdef DEMO_SHIFT_EN
         OP_OR: begin
            f          = a | b;
            next_state = OP_SLL;
         end
         OP_SLL: begin
            f          = a << b[4:0];
            next_state = OP_SRL;
         end
         OP_SRL: begin
            f          = a >> b[4:0];
            next_state = OP_ADD;
         end
`else
         OP_OR: begin
            f          = a | b;
            next_state = OP_ADD;
         end
`endif
         // Unreachable codes compute zero and return to ADD.
         default: begin
            f          = '0;
            next_state = OP_ADD;
         end
      endcase
   end

endmodule

// File: tb/tb_demo_unit.sv
// Self-checking bench for demo_unit: directed vector table on a 32-bit instance,
// plus a wrap-around run of a 10-bit instance against a small reference model.
module tb_demo_unit;

   logic        clk;
   logic        reset;
   logic [31:0] cnt;
   logic [2:0]  op;
   logic [31:0] alu_out;
   logic        zero;
   logic [31:0] checksum;

   logic        reset2;
   logic [9:0]  cnt2;
   logic [2:0]  op2;
   logic [9:0]  alu_out2;
   logic        zero2;
   logic [9:0]  checksum2;

   int checks = 0;
   int errors = 0;

   demo_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .cnt(cnt), .op(op),
      .alu_out(alu_out), .zero(zero), .checksum(checksum)
   );

   demo_unit #(.WIDTH(10)) dut_small (
      .clk(clk), .reset(reset2), .cnt(cnt2), .op(op2),
      .alu_out(alu_out2), .zero(zero2), .checksum(checksum2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [31:0] e_cnt;
      logic [2:0]  e_op;
      logic [31:0] e_alu;
      logic        e_zero;
      logic [31:0] e_chk;
   } vec_t;

   localparam int NVEC = 14;
   vec_t vecs [NVEC];

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Reference model for the 10-bit instance.
   function automatic logic [9:0] model_f(input logic [2:0] o, input logic [9:0] c);
      logic [9:0] bb;
      bb = {c[4:0], c[9:5]};
      case (o)
         3'd0: return c + bb;
         3'd1: return c - bb;
         3'd2: return c & bb;
         3'd3: return c | bb;
`ifdef DEMO_SHIFT_EN
         3'd4: return c << bb[4:0];
         3'd5: return c >> bb[4:0];
`endif
         default: return 10'd0;
      endcase
   endfunction

   function automatic logic [2:0] model_next(input logic [2:0] o);
`ifdef DEMO_SHIFT_EN
      return (o < 3'd5) ? o + 3'd1 : 3'd0;
`else
      return (o < 3'd3) ? o + 3'd1 : 3'd0;
`endif
   endfunction

`ifdef DEMO_SHIFT_EN
   localparam logic [2:0] WRAP_OP = 3'd4;  // 1024 mod 6
`else
   localparam logic [2:0] WRAP_OP = 3'd0;  // 1024 mod 4
`endif

   logic [9:0] m_cnt, m_alu, m_chk, m_f;
   logic [2:0] m_op;
   logic       m_zero;

   initial begin
      reset  = 1'b1;
      reset2 = 1'b1;

      //          rst   cnt    op    alu_out        zero  checksum
      vecs[0]  = '{1'b1, 32'd0, 3'd0, 32'h0000_0000, 1'b1, 32'h0000_0000};
      vecs[1]  = '{1'b1, 32'd0, 3'd0, 32'h0000_0000, 1'b1, 32'h0000_0000};
      vecs[2]  = '{1'b0, 32'd1, 3'd1, 32'h0000_0000, 1'b1, 32'h0000_0000};
      vecs[3]  = '{1'b0, 32'd2, 3'd2, 32'hFFFF_0001, 1'b0, 32'hFFFF_0001};
      vecs[4]  = '{1'b0, 32'd3, 3'd3, 32'h0000_0000, 1'b1, 32'hFFFF_0001};
`ifdef DEMO_SHIFT_EN
      vecs[5]  = '{1'b0, 32'd4, 3'd4, 32'h0003_0003, 1'b0, 32'hFFFC_0002};
      vecs[6]  = '{1'b0, 32'd5, 3'd5, 32'h0000_0004, 1'b0, 32'hFFFC_0006};
      vecs[7]  = '{1'b0, 32'd6, 3'd0, 32'h0000_0005, 1'b0, 32'hFFFC_0003};
      vecs[8]  = '{1'b0, 32'd7, 3'd1, 32'h0006_0006, 1'b0, 32'hFFFA_0005};
`else
      vecs[5]  = '{1'b0, 32'd4, 3'd0, 32'h0003_0003, 1'b0, 32'hFFFC_0002};
      vecs[6]  = '{1'b0, 32'd5, 3'd1, 32'h0004_0004, 1'b0, 32'hFFF8_0006};
      vecs[7]  = '{1'b0, 32'd6, 3'd2, 32'hFFFB_0005, 1'b0, 32'h0003_0003};
      vecs[8]  = '{1'b0, 32'd7, 3'd3, 32'h0000_0000, 1'b1, 32'h0003_0003};
`endif
      vecs[9]  = '{1'b1, 32'd0, 3'd0, 32'h0000_0000, 1'b1, 32'h0000_0000};
      vecs[10] = '{1'b0, 32'd1, 3'd1, 32'h0000_0000, 1'b1, 32'h0000_0000};
      vecs[11] = '{1'b0, 32'd2, 3'd2, 32'hFFFF_0001, 1'b0, 32'hFFFF_0001};
      vecs[12] = '{1'b0, 32'd3, 3'd3, 32'h0000_0000, 1'b1, 32'hFFFF_0001};
      // Mid-sequence reset after the 3rd edge, then recovery reproduces edge 1.
      vecs[13] = '{1'b1, 32'd0, 3'd0, 32'h0000_0000, 1'b1, 32'h0000_0000};

      for (int i = 0; i < NVEC; i++) begin
         reset = vecs[i].rst;
         @(posedge clk);
         @(negedge clk);
         check($sformatf("v%0d cnt", i),      64'(cnt),      64'(vecs[i].e_cnt));
         check($sformatf("v%0d op", i),       64'(op),       64'(vecs[i].e_op));
         check($sformatf("v%0d alu_out", i),  64'(alu_out),  64'(vecs[i].e_alu));
         check($sformatf("v%0d zero", i),     64'(zero),     64'(vecs[i].e_zero));
         check($sformatf("v%0d checksum", i), 64'(checksum), 64'(vecs[i].e_chk));
      end

      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("recovery cnt",     64'(cnt),      64'd1);
      check("recovery op",      64'(op),       64'd1);
      check("recovery alu_out", 64'(alu_out),  64'd0);
      check("recovery zero",    64'(zero),     64'd1);
      check("recovery checksum",64'(checksum), 64'd0);

      // 10-bit instance: run through counter wrap against the model.
      check("small reset cnt",  64'(cnt2),  64'd0);
      check("small reset zero", 64'(zero2), 64'd1);
      reset2 = 1'b0;
      m_cnt  = '0;
      m_op   = '0;
      m_alu  = '0;
      m_zero = 1'b1;
      m_chk  = '0;
      for (int i = 0; i < 1100; i++) begin
         @(posedge clk);
         m_f    = model_f(m_op, m_cnt);
         m_alu  = m_f;
         m_zero = (m_f == 10'd0);
         m_chk  = m_chk ^ m_f;
         m_cnt  = m_cnt + 10'd1;
         m_op   = model_next(m_op);
         @(negedge clk);
         check($sformatf("s%0d cnt", i),      64'(cnt2),      64'(m_cnt));
         check($sformatf("s%0d op", i),       64'(op2),       64'(m_op));
         check($sformatf("s%0d alu_out", i),  64'(alu_out2),  64'(m_alu));
         check($sformatf("s%0d zero", i),     64'(zero2),     64'(m_zero));
         check($sformatf("s%0d checksum", i), 64'(checksum2), 64'(m_chk));
         if (i == 1023) begin
            check("wrap cnt", 64'(cnt2), 64'd0);
            check("wrap op",  64'(op2),  64'(WRAP_OP));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
